// File: rtl/position_collector.sv
// position_collector
//
// Purpose:
//   Sits downstream of a simulation core. On each step_done strobe it snapshots
//   all NODES (x,y) node positions and streams them out, one node per beat, over
//   a valid/ready link toward the host/display side. Each snapshot forms a frame
//   that carries first/last markers and a 16-bit frame number. Snapshots that
//   arrive while a frame is still streaming are dropped and counted.
//
// Configuration macro:
//   POS_COLLECTOR_CHECKSUM_EN - when defined, each frame carries one extra beat
//   after the last node. That beat holds the XOR of all snapshot x values and
//   the XOR of all snapshot y values, with out_index = NODES.
//
// Parameters:
//   NODES   - nodes per frame (1..255)
//   WIDTH   - coordinate width, passed through untouched
//   CORE_ID - constant driven on out_core
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-low reset
//   step_done           - one-cycle strobe; position buses hold a settled step
//   x_pos_flat/y_pos_flat - node i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready - beat handshake
//   out_x/out_y         - coordinates of the current beat
//   out_index           - node index of the current beat
//   out_first/out_last  - frame markers
//   out_frame           - frame number of the snapshot being streamed
//   out_core            - CORE_ID
//   busy                - a frame is being captured or streamed
//   drop_count          - snapshots dropped while busy, saturating
module position_collector #(
  parameter int NODES   = 5,
  parameter int WIDTH   = 32,
  parameter int CORE_ID = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step_done,
  input  logic [NODES*WIDTH-1:0] x_pos_flat,
  input  logic [NODES*WIDTH-1:0] y_pos_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_x,
  output logic [WIDTH-1:0]       out_y,
  output logic [7:0]             out_index,
  output logic                   out_first,
  output logic                   out_last,
  output logic [15:0]            out_frame,
  output logic [7:0]             out_core,
  output logic                   busy,
  output logic [15:0]            drop_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
`ifdef POS_COLLECTOR_CHECKSUM_EN
  localparam logic [1:0] ST_CSUM = 2'd2;
`endif

  logic [1:0]       r_state;
  logic [7:0]       r_idx;
  logic [15:0]      r_frameCnt;
  logic [15:0]      r_frame;
  logic [15:0]      r_dropCnt;
  // Snapshot is kept as a shift register: element 0 is always the node on the
  // output, so no variable indexing into the snapshot is needed.
  logic [WIDTH-1:0] r_xSnap [NODES];
  logic [WIDTH-1:0] r_ySnap [NODES];

  logic w_fire;
  logic w_lastNode;
  logic w_capture;
  logic w_drop;

  assign w_fire     = out_valid && out_ready;
  assign w_lastNode = (r_idx == 8'(NODES - 1));
  assign w_capture  = step_done && (r_state == ST_IDLE);
  assign w_drop     = step_done && (r_state != ST_IDLE);

`ifdef POS_COLLECTOR_CHECKSUM_EN
  logic [WIDTH-1:0] r_xCsum;
  logic [WIDTH-1:0] r_yCsum;
  logic [WIDTH-1:0] w_xXor;
  logic [WIDTH-1:0] w_yXor;

  // Checksum is formed from the live buses so it is ready at capture time.
  always_comb begin
    w_xXor = '0;
    w_yXor = '0;
    for (int i = 0; i < NODES; i++) begin
      w_xXor = w_xXor ^ x_pos_flat[i*WIDTH +: WIDTH];
      w_yXor = w_yXor ^ y_pos_flat[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xCsum <= '0;
      r_yCsum <= '0;
    end else if (w_capture) begin
      r_xCsum <= w_xXor;
      r_yCsum <= w_yXor;
    end
  end
`endif

  // Frame sequencing: index advances only on a handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (step_done) begin
            r_state <= ST_SEND;
            r_idx   <= '0;
          end
        end
        ST_SEND: begin
          if (w_fire) begin
            if (w_lastNode) begin
`ifdef POS_COLLECTOR_CHECKSUM_EN
              r_state <= ST_CSUM;
              r_idx   <= 8'(NODES);
`else
              r_state <= ST_IDLE;
              r_idx   <= '0;
`endif
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
`ifdef POS_COLLECTOR_CHECKSUM_EN
        ST_CSUM: begin
          if (w_fire) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Snapshot capture, then shift one node toward the output per node beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NODES; i++) begin
        r_xSnap[i] <= '0;
        r_ySnap[i] <= '0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < NODES; i++) begin
        r_xSnap[i] <= x_pos_flat[i*WIDTH +: WIDTH];
        r_ySnap[i] <= y_pos_flat[i*WIDTH +: WIDTH];
      end
    end else if (w_fire && (r_state == ST_SEND)) begin
      for (int i = 0; i < NODES - 1; i++) begin
        r_xSnap[i] <= r_xSnap[i+1];
        r_ySnap[i] <= r_ySnap[i+1];
      end
      r_xSnap[NODES-1] <= '0;
      r_ySnap[NODES-1] <= '0;
    end
  end

  // Frame numbering and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frameCnt <= '0;
      r_frame    <= '0;
      r_dropCnt  <= '0;
    end else begin
      if (w_capture) begin
        r_frame    <= r_frameCnt;
        r_frameCnt <= r_frameCnt + 16'd1;
      end
      if (w_drop && (r_dropCnt != 16'hFFFF)) begin
        r_dropCnt <= r_dropCnt + 16'd1;
      end
    end
  end

  always_comb begin
    out_x    = '0;
    out_y    = '0;
    out_last = 1'b0;
    if (r_state == ST_SEND) begin
      out_x = r_xSnap[0];
      out_y = r_ySnap[0];
`ifdef POS_COLLECTOR_CHECKSUM_EN
      out_last = 1'b0;
`else
      out_last = w_lastNode;
`endif
    end
`ifdef POS_COLLECTOR_CHECKSUM_EN
    if (r_state == ST_CSUM) begin
      out_x    = r_xCsum;
      out_y    = r_yCsum;
      out_last = 1'b1;
    end
`endif
  end

  assign out_valid  = (r_state != ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign out_first  = (r_state == ST_SEND) && (r_idx == 8'd0);
  assign out_index  = r_idx;
  assign out_frame  = r_frame;
  assign out_core   = 8'(CORE_ID);
  assign drop_count = r_dropCnt;

endmodule

// File: tb/tb_position_collector.sv
// tb_position_collector
//
// Randomized and directed stimulus for position_collector. Every accepted
// snapshot is expanded into its expected beats and queued; a monitor compares
// each presented beat with the queue head and retires it on handshake.
module tb_position_collector;

  localparam int NODES = 5;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [7:0]       idx;
    logic             first;
    logic             last;
    logic [15:0]      frame;
  } beat_t;

  logic                   clk;
  logic                   reset;
  logic                   step_done;
  logic [NODES*WIDTH-1:0] x_pos_flat;
  logic [NODES*WIDTH-1:0] y_pos_flat;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_x;
  logic [WIDTH-1:0]       out_y;
  logic [7:0]             out_index;
  logic                   out_first;
  logic                   out_last;
  logic [15:0]            out_frame;
  logic [7:0]             out_core;
  logic                   busy;
  logic [15:0]            drop_count;

  beat_t expQ[$];
  int    checks    = 0;
  int    fails     = 0;
  int    expFrame  = 0;
  int    expDrops  = 0;
  int    readyMode = 0;
  int    rdyPhase  = 0;

  position_collector #(.NODES(NODES), .WIDTH(WIDTH), .CORE_ID(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .step_done  (step_done),
    .x_pos_flat (x_pos_flat),
    .y_pos_flat (y_pos_flat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_index  (out_index),
    .out_first  (out_first),
    .out_last   (out_last),
    .out_frame  (out_frame),
    .out_core   (out_core),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected frame from the buses as they stand at the capture edge.
  task automatic pushFrame();
    beat_t b;
`ifdef POS_COLLECTOR_CHECKSUM_EN
    logic [WIDTH-1:0] cx = '0;
    logic [WIDTH-1:0] cy = '0;
`endif
    for (int i = 0; i < NODES; i++) begin
      b.x     = x_pos_flat[i*WIDTH +: WIDTH];
      b.y     = y_pos_flat[i*WIDTH +: WIDTH];
      b.idx   = 8'(i);
      b.first = (i == 0);
      b.last  = (i == NODES - 1);
      b.frame = 16'(expFrame);
`ifdef POS_COLLECTOR_CHECKSUM_EN
      b.last = 1'b0;
      cx = cx ^ b.x;
      cy = cy ^ b.y;
`endif
      expQ.push_back(b);
    end
`ifdef POS_COLLECTOR_CHECKSUM_EN
    b.x = cx; b.y = cy; b.idx = 8'(NODES); b.first = 1'b0; b.last = 1'b1;
    b.frame = 16'(expFrame);
    expQ.push_back(b);
`endif
    expFrame = (expFrame + 1) % 65536;
  endtask

  // Advance one clock; afterwards check busy and drop count against the model.
  task automatic cycle();
    @(posedge clk);
    #1;
    case (readyMode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin out_ready = (rdyPhase % 3 == 0); rdyPhase++; end
      default: out_ready = 1'b0;
    endcase
    checkOutput("busy", 64'(busy), 64'(expQ.size() != 0));
    checkOutput("drop_count", 64'(drop_count), 64'(expDrops));
  endtask

  task automatic applyStimulus(input bit sd, input bit randData);
    bit accepted = 1'b0;
    if (randData) begin
      for (int i = 0; i < NODES; i++) begin
        x_pos_flat[i*WIDTH +: WIDTH] = $urandom;
        y_pos_flat[i*WIDTH +: WIDTH] = $urandom;
      end
    end
    step_done = sd;
    if (sd) begin
      if (expQ.size() == 0) begin
        pushFrame();
        accepted = 1'b1;
      end else if (expDrops < 65535) begin
        expDrops++;
      end
    end
    cycle();
    if (accepted) checkOutput("valid_latency", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && expQ.size() != 0; n++) applyStimulus(1'b0, 1'b1);
    checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
  endtask

  // Scoreboard monitor: held beats must keep matching the queue head.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      checks++;
      if (expQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL spurious_beat: got index %0d, expected no beat", out_index);
      end else begin
        if ({out_x, out_y, out_index, out_first, out_last, out_frame} !== expQ[0]) begin
          fails++;
          $display("[TB] FAIL beat: got x=%h y=%h idx=%0d f=%b l=%b fr=%0d, expected x=%h y=%h idx=%0d f=%b l=%b fr=%0d",
                   out_x, out_y, out_index, out_first, out_last, out_frame,
                   expQ[0].x, expQ[0].y, expQ[0].idx, expQ[0].first, expQ[0].last, expQ[0].frame);
        end
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    repeat (98000) @(posedge clk);
    fails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    reset      = 1'b0;
    step_done  = 1'b0;
    out_ready  = 1'b0;
    x_pos_flat = '0;
    y_pos_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_xy", {out_x, out_y}, 64'd0);
    checkOutput("reset_frame", 64'(out_frame), 64'd0);
    checkOutput("reset_core", 64'(out_core), 64'd0);
    reset = 1'b1;

    // Directed frame 0 with drops mid-frame and on the final handshake.
    $display("[TB] directed frame with drops");
    for (int i = 0; i < NODES; i++) begin
      x_pos_flat[i*WIDTH +: WIDTH] = 32'h1000 + 32'(i);
      y_pos_flat[i*WIDTH +: WIDTH] = 32'h2000 + 32'(i);
    end
    readyMode = 0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("two_drops", 64'(drop_count), 64'd2);
    drain();

    // Backpressure with inputs changing under the frame in flight.
    $display("[TB] backpressure pattern");
    readyMode = 2;
    applyStimulus(1'b1, 1'b1);
    drain();

    // Random traffic.
    $display("[TB] random traffic");
    readyMode = 1;
    for (int n = 0; n < 400; n++) applyStimulus($urandom_range(0, 7) == 0, 1'b1);
    drain();

    // Reset in the middle of a frame.
    $display("[TB] reset mid-frame");
    readyMode = 0;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_reset_xy", {out_x, out_y}, 64'd0);
    checkOutput("mid_reset_idx", {out_index, 6'd0, out_first, out_last}, 64'd0);
    checkOutput("mid_reset_frame", 64'(out_frame), 64'd0);
    expQ.delete();
    expFrame = 0;
    expDrops = 0;
    cycle();
    cycle();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1);
    drain();

    // Drop counter saturation under a permanently stalled sink.
    $display("[TB] drop saturation");
    readyMode = 3;
    applyStimulus(1'b1, 1'b1);
    for (int n = 0; n < 65540; n++) applyStimulus(1'b1, 1'b0);
    checkOutput("drop_saturate", 64'(drop_count), 64'hFFFF);
    readyMode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
